// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares one single-port 8-bit VRAM between the 8088 bus and the CGA fetch engine.
// Optional posted CPU write buffer enabled by defining VRAM_ARB_WPOST_EN.
module vram_arbiter #(
    parameter int RD_LAT      = 1,
    parameter int MAX_VID_RUN = 4,
    parameter int AW          = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_din,
    output logic [7:0]    cpu_dout,
    output logic          cpu_ack,
    output logic          cpu_ready,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_gnt,
    output logic [7:0]    vid_dout,
    output logic          vid_valid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    input  logic [7:0]    mem_dout
);

    // state  | meaning
    // C_IDLE | no CPU access outstanding, CPU may compete for the slot
    // C_BUSY | CPU access issued, waiting for its completion
    // C_DONE | cpu_ack cycle; cpu_req ignored so a held request is not reissued
    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_BUSY = 2'd1,
        C_DONE = 2'd2
    } cpu_state_t;

    localparam logic [3:0] MAX_RUN = 4'(MAX_VID_RUN);

    cpu_state_t      cpu_state;
    logic [3:0]      run_cnt;
    logic [RD_LAT:0] tag_vld;
    logic [RD_LAT:0] tag_cpu;
    logic [RD_LAT:0] tag_rd;

    logic            cpu_elig;
    logic            cpu_gnt;
    logic            slot_we;
    logic [AW-1:0]   slot_addr;
    logic [7:0]      slot_din;
    logic            rd_done;
    logic            wr_done;
    logic            vid_done;

`ifdef VRAM_ARB_WPOST_EN
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [7:0]      wb_data;
    logic            wb_capture;
`endif

    always_comb begin
        cpu_elig  = 1'b0;
        slot_we   = 1'b0;
        slot_addr = cpu_addr;
        slot_din  = cpu_din;
`ifdef VRAM_ARB_WPOST_EN
        // A full buffer drains ahead of any read so read-after-write order holds
        wb_capture = (cpu_state == C_IDLE) && cpu_req && cpu_we && !wb_valid;
        cpu_elig   = wb_valid || ((cpu_state == C_IDLE) && cpu_req && !cpu_we);
        slot_we    = wb_valid;
        slot_addr  = wb_valid ? wb_addr : cpu_addr;
        slot_din   = wb_data;
`else
        cpu_elig   = (cpu_state == C_IDLE) && cpu_req;
        slot_we    = cpu_we;
`endif
        vid_gnt  = vid_req && !(cpu_elig && (run_cnt == MAX_RUN));
        cpu_gnt  = cpu_elig && !vid_gnt;
        rd_done  = tag_vld[RD_LAT] && tag_cpu[RD_LAT] && tag_rd[RD_LAT];
        vid_done = tag_vld[RD_LAT] && !tag_cpu[RD_LAT];
`ifdef VRAM_ARB_WPOST_EN
        wr_done  = wb_capture;
`else
        wr_done  = tag_vld[0] && tag_cpu[0] && !tag_rd[0];
`endif
    end

    assign cpu_ready = ~(cpu_req & ~cpu_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_state <= C_IDLE;
            run_cnt   <= '0;
            tag_vld   <= '0;
            tag_cpu   <= '0;
            tag_rd    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            cpu_dout  <= '0;
            cpu_ack   <= 1'b0;
            vid_dout  <= '0;
            vid_valid <= 1'b0;
`ifdef VRAM_ARB_WPOST_EN
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
`endif
        end else begin
            if (!cpu_elig || cpu_gnt) begin
                run_cnt <= '0;
            end else if (vid_gnt && (run_cnt != MAX_RUN)) begin
                run_cnt <= run_cnt + 4'd1;
            end

            tag_vld <= {tag_vld[RD_LAT-1:0], vid_gnt | cpu_gnt};
            tag_cpu <= {tag_cpu[RD_LAT-1:0], cpu_gnt};
            tag_rd  <= {tag_rd[RD_LAT-1:0], vid_gnt | (cpu_gnt & ~slot_we)};

            if (vid_gnt || cpu_gnt) begin
                mem_en   <= 1'b1;
                mem_we   <= cpu_gnt & slot_we;
                mem_addr <= vid_gnt ? vid_addr : slot_addr;
                if (cpu_gnt) begin
                    mem_din <= slot_din;
                end
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            vid_valid <= vid_done;
            if (vid_done) begin
                vid_dout <= mem_dout;
            end
            cpu_ack <= rd_done | wr_done;
            if (rd_done) begin
                cpu_dout <= mem_dout;
            end

`ifdef VRAM_ARB_WPOST_EN
            if (wb_capture) begin
                wb_valid <= 1'b1;
                wb_addr  <= cpu_addr;
                wb_data  <= cpu_din;
            end else if (cpu_gnt && wb_valid) begin
                wb_valid <= 1'b0;
            end
`endif

            case (cpu_state)
                C_IDLE: begin
`ifdef VRAM_ARB_WPOST_EN
                    if (wb_capture) begin
                        cpu_state <= C_DONE;
                    end else if (cpu_gnt && !wb_valid) begin
                        cpu_state <= C_BUSY;
                    end
`else
                    if (cpu_gnt) begin
                        cpu_state <= C_BUSY;
                    end
`endif
                end
                C_BUSY: begin
                    if (rd_done || wr_done) begin
                        cpu_state <= C_DONE;
                    end
                end
                C_DONE:  cpu_state <= C_IDLE;
                default: cpu_state <= C_IDLE;
            endcase
        end
    end

endmodule
